tlb_lookup_arbiter: RTL and testbench

Shares the single-search-port joint TLB between three requesters: instruction-fetch MMU, data-access MMU, and CP0 TLBP probe. Also blocks lookups around TLBWI/TLBWR writes so no requester sees a stale entry. Sits between the IF/MEM translation units and the TLB array. Each lookup result is registered per requester and returned one cycle after grant.

---
 rtl/tlb_lookup_arbiter.sv | 145 ++++++++++++++
 tb/tb_tlb_lookup_arbiter.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/tlb_lookup_arbiter.sv
// Arbitrates the single TLB search port among inst fetch, data access and TLBP probe,
// and holds off lookups for the cycle of a TLB write and the cycle after it.
module tlb_lookup_arbiter #(
  parameter int TLB_ENTRIES = 16,
  parameter int IDX_W       = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       cp0_asid_i,
  input  logic             inst_req_i,
  input  logic             data_req_i,
  input  logic             tlbp_req_i,
  input  logic [18:0]      inst_vpn2_i,
  input  logic [18:0]      data_vpn2_i,
  input  logic [18:0]      tlbp_vpn2_i,
  input  logic             inst_oddPage_i,
  input  logic             data_oddPage_i,
  input  logic             inst_flush_i,
  input  logic             tlbw_req_i,
  output logic             inst_gnt_o,
  output logic             data_gnt_o,
  output logic             tlbp_gnt_o,
  output logic [18:0]      srch_vpn2_o,
  output logic             srch_oddPage_o,
  output logic [7:0]       srch_asid_o,
  input  logic             srch_hit_i,
  input  logic [IDX_W-1:0] srch_index_i,
  input  logic [19:0]      srch_pfn_i,
  input  logic [2:0]       srch_c_i,
  input  logic             srch_d_i,
  input  logic             srch_v_i,
  output logic             inst_rvalid_o,
  output logic             inst_hit_o,
  output logic [IDX_W-1:0] inst_index_o,
  output logic [19:0]      inst_pfn_o,
  output logic [2:0]       inst_c_o,
  output logic             inst_d_o,
  output logic             inst_v_o,
  output logic             data_rvalid_o,
  output logic             data_hit_o,
  output logic [IDX_W-1:0] data_index_o,
  output logic [19:0]      data_pfn_o,
  output logic [2:0]       data_c_o,
  output logic             data_d_o,
  output logic             data_v_o,
  output logic             tlbp_rvalid_o,
  output logic             tlbp_hit_o,
  output logic [IDX_W-1:0] tlbp_index_o,
  output logic [19:0]      tlbp_pfn_o,
  output logic [2:0]       tlbp_c_o,
  output logic             tlbp_d_o,
  output logic             tlbp_v_o
);

  localparam int RES_W = IDX_W + 26;

  if ($clog2(TLB_ENTRIES) != IDX_W) begin : g_idx_w_check
    $error("IDX_W must equal log2(TLB_ENTRIES)");
  end

  typedef enum logic {RUN, WBLOCK} state_t;

  state_t           state_q, state_d;
  logic             rr_last_q, rr_last_d;   // 1: data won last, 0: inst won last
  logic [2:0]       rvalid_q, rvalid_d;     // {tlbp, data, inst}
  logic [RES_W-1:0] res_q [3];
  logic [RES_W-1:0] res_d [3];
  logic             gnt_inst, gnt_data, gnt_tlbp;
  logic [RES_W-1:0] srch_res;

  assign srch_res = {srch_hit_i, srch_index_i, srch_pfn_i, srch_c_i, srch_d_i, srch_v_i};

  always_comb begin
    state_d   = state_q;
    rr_last_d = rr_last_q;
    gnt_inst  = 1'b0;
    gnt_data  = 1'b0;
    gnt_tlbp  = 1'b0;
    case (state_q)
      RUN:     if (tlbw_req_i) state_d = WBLOCK;
      WBLOCK:  if (!tlbw_req_i) state_d = RUN;
      default: state_d = RUN;
    endcase
    // A write strobe blocks grants regardless of state, so a probe never races the write.
    if (rst && state_q == RUN && !tlbw_req_i) begin
      if (tlbp_req_i) begin
        gnt_tlbp = 1'b1;
      end else if (inst_req_i && data_req_i) begin
        gnt_inst = rr_last_q;
        gnt_data = !rr_last_q;
      end else begin
        gnt_inst = inst_req_i;
        gnt_data = data_req_i;
      end
    end
    if (gnt_inst) rr_last_d = 1'b0;
    if (gnt_data) rr_last_d = 1'b1;
  end

  always_comb begin
    srch_vpn2_o    = inst_vpn2_i;
    srch_oddPage_o = inst_oddPage_i;
    srch_asid_o    = cp0_asid_i;
    if (gnt_data) begin
      srch_vpn2_o    = data_vpn2_i;
      srch_oddPage_o = data_oddPage_i;
    end else if (gnt_tlbp) begin
      srch_vpn2_o    = tlbp_vpn2_i;
      srch_oddPage_o = 1'b0;
    end
  end

  always_comb begin
    rvalid_d = {gnt_tlbp, gnt_data, gnt_inst & ~inst_flush_i};
    for (int i = 0; i < 3; i++) res_d[i] = res_q[i];
    if (gnt_inst) res_d[0] = srch_res;
    if (gnt_data) res_d[1] = srch_res;
    if (gnt_tlbp) res_d[2] = srch_res;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= RUN;
      rr_last_q <= 1'b1;
      rvalid_q  <= '0;
      for (int i = 0; i < 3; i++) res_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      rr_last_q <= rr_last_d;
      rvalid_q  <= rvalid_d;
      for (int i = 0; i < 3; i++) res_q[i] <= res_d[i];
    end
  end

  assign inst_gnt_o    = gnt_inst;
  assign data_gnt_o    = gnt_data;
  assign tlbp_gnt_o    = gnt_tlbp;
  assign inst_rvalid_o = rvalid_q[0];
  assign data_rvalid_o = rvalid_q[1];
  assign tlbp_rvalid_o = rvalid_q[2];
  assign {inst_hit_o, inst_index_o, inst_pfn_o, inst_c_o, inst_d_o, inst_v_o} = res_q[0];
  assign {data_hit_o, data_index_o, data_pfn_o, data_c_o, data_d_o, data_v_o} = res_q[1];
  assign {tlbp_hit_o, tlbp_index_o, tlbp_pfn_o, tlbp_c_o, tlbp_d_o, tlbp_v_o} = res_q[2];

endmodule

// File: tb/tb_tlb_lookup_arbiter.sv
// Bench for tlb_lookup_arbiter: a small TLB answers the search port, a behavioural
// model predicts grants and registered results every cycle, plus directed literal checks.
module tb_tlb_lookup_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  cp0_asid_i;
  logic        inst_req_i, data_req_i, tlbp_req_i;
  logic [18:0] inst_vpn2_i, data_vpn2_i, tlbp_vpn2_i;
  logic        inst_oddPage_i, data_oddPage_i, inst_flush_i, tlbw_req_i;
  logic        inst_gnt_o, data_gnt_o, tlbp_gnt_o;
  logic [18:0] srch_vpn2_o;
  logic        srch_oddPage_o;
  logic [7:0]  srch_asid_o;
  logic        srch_hit_i;
  logic [3:0]  srch_index_i;
  logic [19:0] srch_pfn_i;
  logic [2:0]  srch_c_i;
  logic        srch_d_i, srch_v_i;
  logic        inst_rvalid_o, inst_hit_o, inst_d_o, inst_v_o;
  logic [3:0]  inst_index_o;
  logic [19:0] inst_pfn_o;
  logic [2:0]  inst_c_o;
  logic        data_rvalid_o, data_hit_o, data_d_o, data_v_o;
  logic [3:0]  data_index_o;
  logic [19:0] data_pfn_o;
  logic [2:0]  data_c_o;
  logic        tlbp_rvalid_o, tlbp_hit_o, tlbp_d_o, tlbp_v_o;
  logic [3:0]  tlbp_index_o;
  logic [19:0] tlbp_pfn_o;
  logic [2:0]  tlbp_c_o;

  int checks = 0;
  int errors = 0;

  tlb_lookup_arbiter #(.TLB_ENTRIES(16), .IDX_W(4)) dut (
    .clk(clk), .rst(rst), .cp0_asid_i(cp0_asid_i),
    .inst_req_i(inst_req_i), .data_req_i(data_req_i), .tlbp_req_i(tlbp_req_i),
    .inst_vpn2_i(inst_vpn2_i), .data_vpn2_i(data_vpn2_i), .tlbp_vpn2_i(tlbp_vpn2_i),
    .inst_oddPage_i(inst_oddPage_i), .data_oddPage_i(data_oddPage_i),
    .inst_flush_i(inst_flush_i), .tlbw_req_i(tlbw_req_i),
    .inst_gnt_o(inst_gnt_o), .data_gnt_o(data_gnt_o), .tlbp_gnt_o(tlbp_gnt_o),
    .srch_vpn2_o(srch_vpn2_o), .srch_oddPage_o(srch_oddPage_o), .srch_asid_o(srch_asid_o),
    .srch_hit_i(srch_hit_i), .srch_index_i(srch_index_i), .srch_pfn_i(srch_pfn_i),
    .srch_c_i(srch_c_i), .srch_d_i(srch_d_i), .srch_v_i(srch_v_i),
    .inst_rvalid_o(inst_rvalid_o), .inst_hit_o(inst_hit_o), .inst_index_o(inst_index_o),
    .inst_pfn_o(inst_pfn_o), .inst_c_o(inst_c_o), .inst_d_o(inst_d_o), .inst_v_o(inst_v_o),
    .data_rvalid_o(data_rvalid_o), .data_hit_o(data_hit_o), .data_index_o(data_index_o),
    .data_pfn_o(data_pfn_o), .data_c_o(data_c_o), .data_d_o(data_d_o), .data_v_o(data_v_o),
    .tlbp_rvalid_o(tlbp_rvalid_o), .tlbp_hit_o(tlbp_hit_o), .tlbp_index_o(tlbp_index_o),
    .tlbp_pfn_o(tlbp_pfn_o), .tlbp_c_o(tlbp_c_o), .tlbp_d_o(tlbp_d_o), .tlbp_v_o(tlbp_v_o)
  );

  always #5 clk = ~clk;

  // Tiny TLB: entry i matches tlb_vpn[i]; odd page adds 1 to the PFN.
  logic [18:0] tlb_vpn [16];
  logic [19:0] tlb_pfn [16];
  logic        tlb_val [16];
  int          tlb_ver = 0;

  function automatic logic [29:0] tlb_lookup(input logic [18:0] vpn, input logic odd);
    for (int i = 0; i < 16; i++)
      if (tlb_val[i] && tlb_vpn[i] == vpn)
        return {1'b1, 4'(i), tlb_pfn[i] + {19'b0, odd}, 3'd3, 1'b1, 1'b1};
    return '0;
  endfunction

  always @(srch_vpn2_o, srch_oddPage_o, tlb_ver)
    {srch_hit_i, srch_index_i, srch_pfn_i, srch_c_i, srch_d_i, srch_v_i} =
      tlb_lookup(srch_vpn2_o, srch_oddPage_o);

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  // Behavioural model: grants follow the priority rules, blocked until two cycles after
  // the last write strobe; each granted requester's next result is the TLB answer.
  int          cyc = 0;
  int          blk_until = 0;
  bit          m_known = 0;
  bit          last_was_inst = 0;
  logic [2:0]  m_rv = '0;
  logic [29:0] m_res [3];

  always @(negedge clk) begin
    logic [2:0]  eg;
    logic [18:0] ev;
    logic        eo;
    if (m_known) begin
      chk("inst_rvalid", 32'(inst_rvalid_o), 32'(m_rv[0]));
      chk("data_rvalid", 32'(data_rvalid_o), 32'(m_rv[1]));
      chk("tlbp_rvalid", 32'(tlbp_rvalid_o), 32'(m_rv[2]));
      chk("inst_res", 32'({inst_hit_o, inst_index_o, inst_pfn_o, inst_c_o, inst_d_o, inst_v_o}), 32'(m_res[0]));
      chk("data_res", 32'({data_hit_o, data_index_o, data_pfn_o, data_c_o, data_d_o, data_v_o}), 32'(m_res[1]));
      chk("tlbp_res", 32'({tlbp_hit_o, tlbp_index_o, tlbp_pfn_o, tlbp_c_o, tlbp_d_o, tlbp_v_o}), 32'(m_res[2]));
    end
    eg = '0;
    if (rst && !tlbw_req_i && cyc >= blk_until) begin
      if (tlbp_req_i)                     eg = 3'b100;
      else if (inst_req_i && data_req_i)  eg = last_was_inst ? 3'b010 : 3'b001;
      else                                eg = {1'b0, data_req_i, inst_req_i};
    end
    ev = inst_vpn2_i;
    eo = inst_oddPage_i;
    if (eg[1]) begin ev = data_vpn2_i; eo = data_oddPage_i; end
    if (eg[2]) begin ev = tlbp_vpn2_i; eo = 1'b0; end
    if (m_known) begin
      chk("grants", 32'({tlbp_gnt_o, data_gnt_o, inst_gnt_o}), 32'(eg));
      chk("srch_vpn2", 32'(srch_vpn2_o), 32'(ev));
      chk("srch_odd", 32'(srch_oddPage_o), 32'(eo));
      chk("srch_asid", 32'(srch_asid_o), 32'(cp0_asid_i));
    end
    if (!rst) begin
      m_known = 1;
      m_rv = '0;
      for (int i = 0; i < 3; i++) m_res[i] = '0;
      last_was_inst = 0;
      blk_until = cyc + 1;
    end else begin
      if (tlbw_req_i) blk_until = cyc + 2;
      m_rv = {eg[2], eg[1], eg[0] & ~inst_flush_i};
      for (int i = 0; i < 3; i++) if (eg[i]) m_res[i] = tlb_lookup(ev, eo);
      if (eg[0]) last_was_inst = 1;
      if (eg[1]) last_was_inst = 0;
    end
    cyc++;
  end

  task automatic to_neg();  @(negedge clk); #1; endtask
  task automatic to_next(); @(posedge clk); #1; endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [11:0] seq;
    int          ni, nd;
    rst = 1'b0; cp0_asid_i = 8'h5A;
    inst_req_i = 0; data_req_i = 0; tlbp_req_i = 0; tlbw_req_i = 0; inst_flush_i = 0;
    inst_vpn2_i = '0; data_vpn2_i = '0; tlbp_vpn2_i = '0;
    inst_oddPage_i = 0; data_oddPage_i = 0;
    for (int i = 0; i < 16; i++) begin tlb_vpn[i] = '0; tlb_pfn[i] = '0; tlb_val[i] = 0; end
    tlb_vpn[0] = 19'h00400; tlb_pfn[0] = 20'h1F000; tlb_val[0] = 1;
    tlb_vpn[1] = 19'h00500; tlb_pfn[1] = 20'h12340; tlb_val[1] = 1;
    tlb_vpn[2] = 19'h00600; tlb_pfn[2] = 20'h0ABC0; tlb_val[2] = 1;
    tlb_ver++;
    repeat (2) to_next();
    chk("rst_inst_rvalid", 32'(inst_rvalid_o), 0);
    chk("rst_inst_pfn", 32'(inst_pfn_o), 0);
    rst = 1'b1;

    // single inst lookup
    inst_req_i = 1; inst_vpn2_i = 19'h00400;
    to_neg(); chk("t1_inst_gnt", 32'(inst_gnt_o), 1);
    to_next(); inst_req_i = 0;
    chk("t1_inst_rvalid", 32'(inst_rvalid_o), 1);
    chk("t1_inst_pfn", 32'(inst_pfn_o), 32'h1F000);
    chk("t1_data_pfn", 32'(data_pfn_o), 0);
    chk("t1_data_rvalid", 32'(data_rvalid_o), 0);

    // lone data request, odd page, right after an inst win
    data_req_i = 1; data_vpn2_i = 19'h00500; data_oddPage_i = 1;
    to_neg(); chk("lone_data_gnt", 32'(data_gnt_o), 1);
    to_next(); data_req_i = 0;
    chk("lone_data_pfn", 32'(data_pfn_o), 32'h12341);

    // both requesting for 6 cycles
    inst_req_i = 1; data_req_i = 1; inst_vpn2_i = 19'h00600; data_vpn2_i = 19'h00400;
    data_oddPage_i = 0; seq = '0; ni = 0; nd = 0;
    for (int k = 0; k < 6; k++) begin
      to_neg(); seq = {seq[9:0], inst_gnt_o, data_gnt_o};
      to_next();
      if (k == 5) begin inst_req_i = 0; data_req_i = 0; end
      ni += int'(inst_rvalid_o); nd += int'(data_rvalid_o);
    end
    chk("rr_seq", 32'(seq), 32'h999);
    chk("rr_inst_rvalids", 32'(ni), 3);
    chk("rr_data_rvalids", 32'(nd), 3);

    // probe against pending inst and data
    tlbp_req_i = 1; tlbp_vpn2_i = 19'h00500; inst_req_i = 1; data_req_i = 1;
    to_neg(); chk("tlbp_first", 32'(tlbp_gnt_o), 1);
    to_next(); tlbp_req_i = 0;
    chk("tlbp_index", 32'(tlbp_index_o), 1);
    chk("tlbp_rvalid", 32'(tlbp_rvalid_o), 1);
    to_neg(); chk("after_tlbp_inst", 32'(inst_gnt_o), 1);
    to_next(); inst_req_i = 0;
    to_neg(); chk("after_tlbp_data", 32'(data_gnt_o), 1);
    to_next(); data_req_i = 0;

    // write hazard with inst held; CP0 rewrites entry 0 on the write edge
    to_next();
    tlbw_req_i = 1; inst_req_i = 1; inst_vpn2_i = 19'h00400;
    to_neg(); chk("w_gnt_w", 32'(inst_gnt_o), 0);
    to_next(); tlbw_req_i = 0; tlb_pfn[0] = 20'h2A000; tlb_ver++;
    to_neg(); chk("w_gnt_w1", 32'(inst_gnt_o), 0);
    to_next();
    to_neg(); chk("w_gnt_w2", 32'(inst_gnt_o), 1);
    to_next(); inst_req_i = 0;
    chk("w_post_write_pfn", 32'(inst_pfn_o), 32'h2A000);

    // back-to-back writes with a probe waiting
    tlbw_req_i = 1; tlbp_req_i = 1; tlbp_vpn2_i = 19'h00600;
    to_next();
    to_next(); tlbw_req_i = 0;
    to_neg(); chk("ww_tlbp_blocked", 32'(tlbp_gnt_o), 0);
    to_next();
    to_neg(); chk("ww_tlbp_gnt", 32'(tlbp_gnt_o), 1);
    to_next(); tlbp_req_i = 0;

    // flush in the grant cycle, then flush only in the rvalid cycle
    inst_req_i = 1; inst_vpn2_i = 19'h00600; inst_flush_i = 1;
    to_next(); inst_req_i = 0; inst_flush_i = 0;
    chk("flush_rvalid", 32'(inst_rvalid_o), 0);
    chk("flush_pfn", 32'(inst_pfn_o), 32'h0ABC0);
    inst_req_i = 1; inst_vpn2_i = 19'h00400;
    to_next(); inst_req_i = 0; inst_flush_i = 1;
    chk("noflush_rvalid", 32'(inst_rvalid_o), 1);
    chk("noflush_pfn", 32'(inst_pfn_o), 32'h2A000);
    to_next(); inst_flush_i = 0;

    // reset right after a data grant
    data_req_i = 1; data_vpn2_i = 19'h00600;
    to_next(); data_req_i = 0; rst = 0; inst_req_i = 1;
    chk("pre_rst_data_rvalid", 32'(data_rvalid_o), 1);
    to_neg(); chk("gnt_in_rst", 32'({tlbp_gnt_o, data_gnt_o, inst_gnt_o}), 0);
    to_next(); rst = 1; data_req_i = 1;
    chk("rst_data_rvalid", 32'(data_rvalid_o), 0);
    chk("rst_data_pfn", 32'(data_pfn_o), 0);
    chk("rst_inst_pfn2", 32'(inst_pfn_o), 0);
    chk("rst_tlbp_index", 32'(tlbp_index_o), 0);
    to_neg(); chk("post_rst_inst_first", 32'(inst_gnt_o), 1);
    to_next(); inst_req_i = 0;
    to_next(); data_req_i = 0;
    repeat (3) to_next();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
